// File: rtl/fft_mem_pkg.sv
// Shared definitions for the FFT ping-pong sample store:
// frame state encoding, point-count derivation and bit reversal.
package fft_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        UNLOAD  = 2'd3
    } state_e;

    localparam int unsigned MAX_AW = 32;

    function automatic int unsigned num_points(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Reverse the low w bits of v; bits above w come back as zero.
    function automatic logic [MAX_AW-1:0] bitrev(
        input logic [MAX_AW-1:0] v,
        input int unsigned       w
    );
        logic [MAX_AW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_AW); i++) begin
            if (i < int'(w)) begin
                r[i] = v[int'(w) - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_mem_bank.sv
// One complex sample bank: two synchronous write ports and two
// registered read ports sharing a single read enable.
module fft_mem_bank #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_a_i,
    input  logic [AW-1:0] wa_a_i,
    input  logic [DW-1:0] wd_a_re_i,
    input  logic [DW-1:0] wd_a_im_i,
    input  logic          we_b_i,
    input  logic [AW-1:0] wa_b_i,
    input  logic [DW-1:0] wd_b_re_i,
    input  logic [DW-1:0] wd_b_im_i,
    input  logic          re_i,
    input  logic [AW-1:0] ra_a_i,
    input  logic [AW-1:0] ra_b_i,
    output logic [DW-1:0] rd_a_re_o,
    output logic [DW-1:0] rd_a_im_o,
    output logic [DW-1:0] rd_b_re_o,
    output logic [DW-1:0] rd_b_im_o
);

    logic [2*DW-1:0] mem_q [2**AW];

    // Port B is written first so port A wins on an address collision.
    always_ff @(posedge clk) begin
        if (we_b_i) begin
            mem_q[wa_b_i] <= {wd_b_re_i, wd_b_im_i};
        end
        if (we_a_i) begin
            mem_q[wa_a_i] <= {wd_a_re_i, wd_a_im_i};
        end
    end

    // Read registers capture only on a read so data holds in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_re_o <= '0;
            rd_a_im_o <= '0;
            rd_b_re_o <= '0;
            rd_b_im_o <= '0;
        end else if (re_i) begin
            {rd_a_re_o, rd_a_im_o} <= mem_q[ra_a_i];
            {rd_b_re_o, rd_b_im_o} <= mem_q[ra_b_i];
        end
    end

endmodule

// File: rtl/fft_pingpong_buffer.sv
// Ping-pong sample store for the radix-2 FFT: serial load, per-stage
// bank swapping for the butterflies, and handshaked serial unload.
module fft_pingpong_buffer
    import fft_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 5,
    parameter int STAGE_W     = 3,
    parameter int BITREV_LOAD = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_real,
    input  logic [DATA_WIDTH-1:0] load_imag,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr_A_read,
    input  logic [ADDR_WIDTH-1:0] addr_B_read,
    output logic [DATA_WIDTH-1:0] A_real_out,
    output logic [DATA_WIDTH-1:0] A_imag_out,
    output logic [DATA_WIDTH-1:0] B_real_out,
    output logic [DATA_WIDTH-1:0] B_imag_out,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr_A_write,
    input  logic [ADDR_WIDTH-1:0] addr_B_write,
    input  logic [DATA_WIDTH-1:0] A_real_in,
    input  logic [DATA_WIDTH-1:0] A_imag_in,
    input  logic [DATA_WIDTH-1:0] B_real_in,
    input  logic [DATA_WIDTH-1:0] B_imag_in,
    input  logic                  stage_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic [STAGE_W-1:0]    stage,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int unsigned N = num_points(ADDR_WIDTH);

    state_e             state_q;
    logic               src_q;
    logic               rsel_q;
    logic [AW-1:0]      ld_cnt_q;
    logic [AW:0]        rd_cnt_q;
    logic [AW-1:0]      out_index_q;
    logic [STAGE_W-1:0] stage_q;
    logic               load_ready_q;
    logic               rd_valid_q;
    logic               out_valid_q;
    logic               frame_done_q;

    logic          ld_fire;
    logic          cmp_rd;
    logic          cmp_wr;
    logic          ul_issue;
    logic          ul_fire;
    logic          ul_last;
    logic [AW-1:0] ld_addr;
    logic [AW-1:0] ra_a;

    logic [DW-1:0] b0_a_re, b0_a_im, b0_b_re, b0_b_im;
    logic [DW-1:0] b1_a_re, b1_a_im, b1_b_re, b1_b_im;

    assign ld_fire  = (state_q == LOAD) & load_valid & load_ready_q;
    assign cmp_rd   = (state_q == COMPUTE) & rd_en;
    assign cmp_wr   = (state_q == COMPUTE) & wr_en;
    assign ul_fire  = (state_q == UNLOAD) & out_valid_q & out_ready;
    assign ul_issue = (state_q == UNLOAD) & ~rd_cnt_q[AW]
                    & (~out_valid_q | out_ready);
    assign ul_last  = ul_fire & (out_index_q == AW'(N - 1));

    assign ld_addr = (BITREV_LOAD != 0)
                   ? AW'(bitrev(MAX_AW'(ld_cnt_q), AW))
                   : ld_cnt_q;
    assign ra_a    = ul_issue ? rd_cnt_q[AW-1:0] : addr_A_read;

    fft_mem_bank #(.DW(DW), .AW(AW)) u_bank0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_a_i    (ld_fire | (cmp_wr & src_q)),
        .wa_a_i    (ld_fire ? ld_addr : addr_A_write),
        .wd_a_re_i (ld_fire ? load_real : A_real_in),
        .wd_a_im_i (ld_fire ? load_imag : A_imag_in),
        .we_b_i    (cmp_wr & src_q),
        .wa_b_i    (addr_B_write),
        .wd_b_re_i (B_real_in),
        .wd_b_im_i (B_imag_in),
        .re_i      ((cmp_rd | ul_issue) & ~src_q),
        .ra_a_i    (ra_a),
        .ra_b_i    (addr_B_read),
        .rd_a_re_o (b0_a_re),
        .rd_a_im_o (b0_a_im),
        .rd_b_re_o (b0_b_re),
        .rd_b_im_o (b0_b_im)
    );

    fft_mem_bank #(.DW(DW), .AW(AW)) u_bank1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_a_i    (cmp_wr & ~src_q),
        .wa_a_i    (addr_A_write),
        .wd_a_re_i (A_real_in),
        .wd_a_im_i (A_imag_in),
        .we_b_i    (cmp_wr & ~src_q),
        .wa_b_i    (addr_B_write),
        .wd_b_re_i (B_real_in),
        .wd_b_im_i (B_imag_in),
        .re_i      ((cmp_rd | ul_issue) & src_q),
        .ra_a_i    (ra_a),
        .ra_b_i    (addr_B_read),
        .rd_a_re_o (b1_a_re),
        .rd_a_im_o (b1_a_im),
        .rd_b_re_o (b1_b_re),
        .rd_b_im_o (b1_b_im)
    );

    assign A_real_out = rsel_q ? b1_a_re : b0_a_re;
    assign A_imag_out = rsel_q ? b1_a_im : b0_a_im;
    assign B_real_out = rsel_q ? b1_b_re : b0_b_re;
    assign B_imag_out = rsel_q ? b1_b_im : b0_b_im;
    assign out_real   = A_real_out;
    assign out_imag   = A_imag_out;
    assign out_index  = out_index_q;
    assign out_valid  = out_valid_q;
    assign load_ready = load_ready_q;
    assign rd_valid   = rd_valid_q;
    assign stage      = stage_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

    // Frame sequencer: load, per-stage bank swap, handshaked unload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= 1'b0;
            rsel_q       <= 1'b0;
            ld_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            out_index_q  <= '0;
            stage_q      <= '0;
            load_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            rd_valid_q   <= cmp_rd;
            if (cmp_rd | ul_issue) begin
                rsel_q <= src_q;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= LOAD;
                        ld_cnt_q     <= '0;
                        load_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_fire) begin
                        ld_cnt_q <= ld_cnt_q + 1'b1;
                        if (ld_cnt_q == AW'(N - 1)) begin
                            state_q      <= COMPUTE;
                            load_ready_q <= 1'b0;
                            src_q        <= 1'b0;
                            stage_q      <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (stage_done) begin
                        src_q   <= ~src_q;
                        stage_q <= stage_q + 1'b1;
                        if (stage_q == STAGE_W'(AW - 1)) begin
                            state_q     <= UNLOAD;
                            rd_cnt_q    <= '0;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                UNLOAD: begin
                    if (ul_issue) begin
                        rd_cnt_q    <= rd_cnt_q + 1'b1;
                        out_index_q <= rd_cnt_q[AW-1:0];
                        out_valid_q <= 1'b1;
                    end else if (ul_fire) begin
                        out_valid_q <= 1'b0;
                    end
                    if (ul_last) begin
                        frame_done_q <= 1'b1;
                        out_valid_q  <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Directed bench for fft_pingpong_buffer (N = 32, bit-reversed load).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fft_pingpong_buffer;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int SW = 3;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] load_real = '0;
    logic [DW-1:0] load_imag = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] addr_A_read = '0;
    logic [AW-1:0] addr_B_read = '0;
    logic [DW-1:0] A_real_out, A_imag_out, B_real_out, B_imag_out;
    logic          rd_valid;
    logic          wr_en = 1'b0;
    logic [AW-1:0] addr_A_write = '0;
    logic [AW-1:0] addr_B_write = '0;
    logic [DW-1:0] A_real_in = '0;
    logic [DW-1:0] A_imag_in = '0;
    logic [DW-1:0] B_real_in = '0;
    logic [DW-1:0] B_imag_in = '0;
    logic          stage_done = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_real, out_imag;
    logic [AW-1:0] out_index;
    logic [SW-1:0] stage;
    logic          busy;
    logic          frame_done;

    int nvec = 0;
    int nerr = 0;

    fft_pingpong_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .STAGE_W    (SW),
        .BITREV_LOAD(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_real    (load_real),
        .load_imag    (load_imag),
        .rd_en        (rd_en),
        .addr_A_read  (addr_A_read),
        .addr_B_read  (addr_B_read),
        .A_real_out   (A_real_out),
        .A_imag_out   (A_imag_out),
        .B_real_out   (B_real_out),
        .B_imag_out   (B_imag_out),
        .rd_valid     (rd_valid),
        .wr_en        (wr_en),
        .addr_A_write (addr_A_write),
        .addr_B_write (addr_B_write),
        .A_real_in    (A_real_in),
        .A_imag_in    (A_imag_in),
        .B_real_in    (B_real_in),
        .B_imag_in    (B_imag_in),
        .stage_done   (stage_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_real     (out_real),
        .out_imag     (out_imag),
        .out_index    (out_index),
        .stage        (stage),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input int base);
        for (int k = 0; k < N; k++) begin
            load_valid = 1'b1;
            load_real  = DW'(base + k);
            load_imag  = '0;
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_load_ready", 32'(load_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_stage", 32'(stage), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_A_real", 32'(A_real_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // compute-side controls are ignored while idle
        rd_en = 1'b1; wr_en = 1'b1; stage_done = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; stage_done = 1'b0;
        chk("idle_rd_valid", 32'(rd_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_stage", 32'(stage), 0);

        // start -> LOAD
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_load_ready", 32'(load_ready), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_stage", 32'(stage), 0);

        // bit-reversed load of real = k
        load_frame(0);
        chk("load_done_ready", 32'(load_ready), 0);

        // stage 0 reads: addr 1 -> 16, addr 3 -> 24
        rd_en = 1'b1; addr_A_read = 5'd1; addr_B_read = 5'd3;
        @(negedge clk);
        rd_en = 1'b0;
        chk("s0_rd_valid", 32'(rd_valid), 1);
        chk("s0_A_real", 32'(A_real_out), 32'd16);
        chk("s0_A_imag", 32'(A_imag_out), 32'd0);
        chk("s0_B_real", 32'(B_real_out), 32'd24);
        @(negedge clk);
        chk("s0_rd_valid_drop", 32'(rd_valid), 0);
        chk("s0_A_hold", 32'(A_real_out), 32'd16);

        // stage 0 write into the other bank, then swap
        wr_en = 1'b1;
        addr_A_write = 5'd0; A_real_in = 16'h1234; A_imag_in = 16'h0001;
        addr_B_write = 5'd2; B_real_in = 16'h2222; B_imag_in = 16'h0002;
        @(negedge clk);
        wr_en = 1'b0; stage_done = 1'b1;
        @(negedge clk);
        stage_done = 1'b0;
        chk("s1_stage", 32'(stage), 1);

        // stage 1 reads back what stage 0 wrote
        rd_en = 1'b1; addr_A_read = 5'd0; addr_B_read = 5'd2;
        @(negedge clk);
        rd_en = 1'b0;
        chk("s1_rd_valid", 32'(rd_valid), 1);
        chk("s1_A_real", 32'(A_real_out), 32'h1234);
        chk("s1_A_imag", 32'(A_imag_out), 32'h0001);
        chk("s1_B_real", 32'(B_real_out), 32'h2222);

        // same-address write: port A wins
        wr_en = 1'b1;
        addr_A_write = 5'd7; A_real_in = 16'hAAAA; A_imag_in = 16'h1111;
        addr_B_write = 5'd7; B_real_in = 16'h5555; B_imag_in = 16'h2222;
        @(negedge clk);
        // write together with stage_done lands pre-swap
        addr_A_write = 5'd9;  A_real_in = 16'h0909; A_imag_in = 16'h0000;
        addr_B_write = 5'd10; B_real_in = 16'h0A0A; B_imag_in = 16'h0000;
        stage_done = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; stage_done = 1'b0;
        chk("s2_stage", 32'(stage), 2);

        rd_en = 1'b1; addr_A_read = 5'd7; addr_B_read = 5'd9;
        @(negedge clk);
        rd_en = 1'b0;
        chk("s2_collide_A", 32'(A_real_out), 32'hAAAA);
        chk("s2_collide_Aim", 32'(A_imag_out), 32'h1111);
        chk("s2_wr_swap_B", 32'(B_real_out), 32'h0909);

        // read together with stage_done uses pre-swap source
        rd_en = 1'b1; addr_A_read = 5'd10; addr_B_read = 5'd4;
        stage_done = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; stage_done = 1'b0;
        chk("s2_rd_swap_A", 32'(A_real_out), 32'h0A0A);
        chk("s2_rd_swap_B", 32'(B_real_out), 32'd4);
        chk("s3_stage", 32'(stage), 3);

        stage_done = 1'b1;
        @(negedge clk);
        stage_done = 1'b0;
        chk("s4_stage", 32'(stage), 4);

        // last stage fills the final bank with 0x100+i / 0x200+i
        for (int i = 0; i < N / 2; i++) begin
            wr_en = 1'b1;
            addr_A_write = AW'(i);
            A_real_in = DW'(32'h100 + i);
            A_imag_in = DW'(32'h200 + i);
            addr_B_write = AW'(i + 16);
            B_real_in = DW'(32'h100 + i + 16);
            B_imag_in = DW'(32'h200 + i + 16);
            @(negedge clk);
        end
        wr_en = 1'b0;
        stage_done = 1'b1;
        @(negedge clk);
        stage_done = 1'b0;
        chk("s5_stage", 32'(stage), 5);

        for (int t = 0; t < 8; t++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        chk("ul_first_valid", 32'(out_valid), 1);
        chk("ul_idx0", 32'(out_index), 0);
        chk("ul_real0", 32'(out_real), 32'h100);

        // backpressure 1,0,0,1
        out_ready = 1'b1;
        @(negedge clk);
        chk("ul_idx1", 32'(out_index), 1);
        chk("ul_real1", 32'(out_real), 32'h101);
        out_ready = 1'b0;
        @(negedge clk);
        chk("ul_stall1_idx", 32'(out_index), 1);
        chk("ul_stall1_real", 32'(out_real), 32'h101);
        @(negedge clk);
        chk("ul_stall2_idx", 32'(out_index), 1);
        chk("ul_stall2_imag", 32'(out_imag), 32'h201);
        chk("ul_stall2_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clk);

        for (int i = 2; i < N; i++) begin
            chk("ul_valid", 32'(out_valid), 1);
            chk("ul_idx", 32'(out_index), 32'(i));
            chk("ul_real", 32'(out_real), 32'h100 + 32'(i));
            chk("ul_fd_early", 32'(frame_done), 0);
            @(negedge clk);
        end
        chk("fd_pulse", 32'(frame_done), 1);
        chk("fd_out_valid", 32'(out_valid), 0);
        chk("fd_busy", 32'(busy), 0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("fd_single", 32'(frame_done), 0);

        // second frame, aborted by reset mid-unload
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("f2_load_ready", 32'(load_ready), 1);
        load_frame(32'h40);
        stage_done = 1'b1;
        repeat (5) @(negedge clk);
        stage_done = 1'b0;
        chk("f2_stage", 32'(stage), 5);
        out_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (out_valid && out_index == 5'd10) break;
            @(negedge clk);
        end
        chk("f2_idx10", 32'(out_index), 32'd10);
        chk("f2_real10", 32'(out_real), 32'h10A);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_stage", 32'(stage), 0);
        chk("abort_load_ready", 32'(load_ready), 0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // clean reload after abort
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("f3_load_ready", 32'(load_ready), 1);
        load_frame(32'h80);
        chk("f3_busy", 32'(busy), 1);
        rd_en = 1'b1; addr_A_read = 5'd1; addr_B_read = 5'd3;
        @(negedge clk);
        rd_en = 1'b0;
        chk("f3_rd_valid", 32'(rd_valid), 1);
        chk("f3_A_real", 32'(A_real_out), 32'h90);
        chk("f3_B_real", 32'(B_real_out), 32'h98);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
